// File: rtl/ps2_dev_tx.sv
// Device-side PS/2 transmitter: 16-deep FWFT byte FIFO feeding an 11-bit
// device-to-host frame serializer that backs off when the host inhibits the clock.
module ps2_dev_tx #(
  parameter int unsigned CLK_DIV    = 1000,
  parameter int unsigned GAP_CYCLES = 2000,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_wr,
  output logic       full,
  output logic       overflow,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  output logic       busy
);

  localparam int unsigned DEPTH   = 1 << FIFO_AW;
  localparam int unsigned CNT_W   = FIFO_AW + 1;
  localparam int unsigned DIV_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic               r_sync_meta;
  logic               r_hclk;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_full;
  logic               r_overflow;
  logic [1:0]         r_state;
  logic [10:0]        r_sr;
  logic [3:0]         r_bcnt;
  logic [DIV_W-1:0]   r_div;
  logic               r_clk_out;
  logic               r_dat_out;
  logic               r_busy;

  logic               w_wr;
  logic               w_pop;
  logic               w_empty;
  logic [7:0]         w_head;
  logic [CNT_W-1:0]   w_count_nx;
  logic               w_div_end_clk;
  logic               w_div_end_gap;
  logic [1:0]         w_state_nx;
  logic [10:0]        w_sr_nx;
  logic [3:0]         w_bcnt_nx;
  logic [DIV_W-1:0]   w_div_nx;

  assign full        = r_full;
  assign overflow    = r_overflow;
  assign ps2_clk_out = r_clk_out;
  assign ps2_dat_out = r_dat_out;
  assign busy        = r_busy;

  assign w_wr          = din_wr && !r_full;
  assign w_empty       = (r_count == '0);
  assign w_head        = r_mem[r_rptr];
  assign w_div_end_clk = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_div_end_gap = (r_div == DIV_W'(GAP_CYCLES - 1));

  // Host clock line synchronizer; released line reads high.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_sync_meta <= 1'b1;
      r_hclk      <= 1'b1;
    end else begin
      r_sync_meta <= ps2_clk_in;
      r_hclk      <= r_sync_meta;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_wr) r_mem[r_wptr] <= din;
  end

  always_comb begin
    w_count_nx = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nx = r_count + CNT_W'(1);
      2'b01:   w_count_nx = r_count - CNT_W'(1);
      default: w_count_nx = r_count;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop) r_rptr <= r_rptr + FIFO_AW'(1);
      r_count    <= w_count_nx;
      r_full     <= (w_count_nx == CNT_W'(DEPTH));
      r_overflow <= din_wr && r_full;
    end
  end

  // Frame sequencer: the head byte is popped only after its stop bit completes.
  always_comb begin
    w_state_nx = r_state;
    w_sr_nx    = r_sr;
    w_bcnt_nx  = r_bcnt;
    w_div_nx   = r_div + DIV_W'(1);
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_nx = '0;
        if (!w_empty && r_hclk) begin
          w_state_nx = S_HIGH;
          w_sr_nx    = {1'b1, ~^w_head, w_head, 1'b0};
          w_bcnt_nx  = 4'd0;
        end
      end
      S_HIGH: begin
        if (r_bcnt != 4'd0 && !r_hclk) begin
          w_state_nx = S_GAP;
          w_div_nx   = '0;
        end else if (w_div_end_clk) begin
          w_state_nx = S_LOW;
          w_div_nx   = '0;
        end
      end
      S_LOW: begin
        if (w_div_end_clk) begin
          w_div_nx = '0;
          if (r_bcnt < 4'd10) begin
            w_sr_nx    = {1'b0, r_sr[10:1]};
            w_bcnt_nx  = r_bcnt + 4'd1;
            w_state_nx = S_HIGH;
          end else begin
            w_pop      = 1'b1;
            w_state_nx = S_GAP;
          end
        end
      end
      default: begin
        if (w_div_end_gap) begin
          w_state_nx = S_IDLE;
          w_div_nx   = '0;
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they track the state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sr      <= '0;
      r_bcnt    <= '0;
      r_div     <= '0;
      r_clk_out <= 1'b1;
      r_dat_out <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_sr      <= w_sr_nx;
      r_bcnt    <= w_bcnt_nx;
      r_div     <= w_div_nx;
      r_clk_out <= (w_state_nx != S_LOW);
      r_dat_out <= (w_state_nx == S_HIGH || w_state_nx == S_LOW) ? w_sr_nx[0] : 1'b1;
      r_busy    <= (w_state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Scoreboard bench for ps2_dev_tx: directed writes queue expected bytes, a
// monitor decodes frames from the PS/2 output lines and compares in order.
module tb_ps2_dev_tx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYCLES = 8;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_wr;
  logic       full;
  logic       overflow;
  logic       ps2_clk_in;
  logic       ps2_clk_out;
  logic       ps2_dat_out;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  ps2_dev_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .FIFO_AW(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .din(din), .din_wr(din_wr),
    .full(full), .overflow(overflow), .ps2_clk_in(ps2_clk_in),
    .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(b[i]);
    return (c % 2) == 0;
  endfunction

  // Monitor: capture data on each falling device clock, check LOW width.
  logic [10:0] mon_frame = '0;
  int          mon_n = 0;
  int          low_len = 0;
  logic        prev_clk = 1'b1;
  logic [7:0]  exp_b;

  always @(negedge clk_sys) begin
    if (reset || !busy) begin
      mon_n   = 0;
      low_len = 0;
    end else begin
      if (prev_clk && !ps2_clk_out) begin
        mon_frame[mon_n] = ps2_dat_out;
        mon_n++;
        low_len = 0;
        if (mon_n == 11) begin
          mon_n = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", int'(mon_frame), 0);
          end else begin
            exp_b = exp_q.pop_front();
            chk("frame", int'(mon_frame), int'({1'b1, odd_par(exp_b), exp_b, 1'b0}));
          end
        end
      end
      if (!ps2_clk_out) low_len++;
      if (!prev_clk && ps2_clk_out) chk("low_width", low_len, CLK_DIV);
    end
    prev_clk = ps2_clk_out;
  end

  task automatic write_byte(input logic [7:0] b);
    din    = b;
    din_wr = 1'b1;
    @(negedge clk_sys);
    din_wr = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int maxc, input string name, output int n);
    n = 0;
    while (busy !== lvl && n < maxc) begin
      @(negedge clk_sys);
      n++;
    end
    if (busy !== lvl) chk(name, int'(busy), int'(lvl));
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      @(negedge clk_sys);
      n++;
    end
    chk(name, exp_q.size() + int'(busy), 0);
  endtask

  int n, t1, t2, lows, starts;

  initial begin
    reset = 1'b1; ps2_clk_in = 1'b1; din = '0; din_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_clk", int'(ps2_clk_out), 1);
    chk("rst_dat", int'(ps2_dat_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Single byte 0x1C: start bit two cycles after the write strobe.
    exp_q.push_back(8'h1C);
    write_byte(8'h1C);
    chk("start_busy_early", int'(busy), 0);
    @(negedge clk_sys);
    chk("start_busy", int'(busy), 1);
    chk("start_dat", int'(ps2_dat_out), 0);
    wait_busy(1'b0, 200, "busy_fall_timeout", n);
    chk("busy_fall_delay", n, 22 * CLK_DIV + GAP_CYCLES);
    chk("sb_queue", exp_q.size(), 0);

    // Parity 0x00 then 0xFF back to back; start-to-start spacing.
    repeat (2) @(negedge clk_sys);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    write_byte(8'h00);
    write_byte(8'hFF);
    wait_busy(1'b1, 20, "par_start1_timeout", n);
    t1 = cyc;
    wait_busy(1'b0, 200, "par_gap_timeout", n);
    wait_busy(1'b1, 20, "par_start2_timeout", n);
    t2 = cyc;
    chk("start_to_start", t2 - t1, 22 * CLK_DIV + GAP_CYCLES + 1);
    wait_drain(300, "par_drain");

    // FIFO full / overflow with host inhibiting.
    ps2_clk_in = 1'b0;
    repeat (4) @(negedge clk_sys);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i + 1));
      write_byte(8'(i + 1));
      chk($sformatf("full_%0d", i), int'(full), (i >= 15) ? 1 : 0);
      chk($sformatf("ovf_%0d", i), int'(overflow), (i == 16) ? 1 : 0);
    end
    @(negedge clk_sys);
    chk("ovf_single_pulse", int'(overflow), 0);
    chk("inhibit_idle", int'(busy), 0);
    ps2_clk_in = 1'b1;
    wait_drain(3000, "fifo_drain");
    chk("drained_full", int'(full), 0);

    // Inhibit abort during D3 HIGH of 0xA5, then full resend.
    exp_q.push_back(8'hA5);
    write_byte(8'hA5);
    wait_busy(1'b1, 20, "ab_start_timeout", n);
    repeat (32) @(negedge clk_sys);
    chk("ab_d3_bit", int'(ps2_dat_out), 0);
    chk("ab_d3_high", int'(ps2_clk_out), 1);
    ps2_clk_in = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("ab_dat_released", int'(ps2_dat_out), 1);
    chk("ab_in_gap", int'(busy), 1);
    lows = 0;
    repeat (40) begin
      @(negedge clk_sys);
      if (!ps2_clk_out) lows++;
    end
    chk("ab_no_clock", lows, 0);
    chk("ab_held_idle", int'(busy), 0);
    chk("ab_pending", exp_q.size(), 1);
    ps2_clk_in = 1'b1;
    wait_drain(300, "ab_drain");
    starts = 0;
    repeat (150) begin
      @(negedge clk_sys);
      if (busy) starts++;
    end
    chk("ab_popped_once", starts, 0);

    // Write lands on the cycle the stop-bit LOW ends (pop + write together).
    ps2_clk_in = 1'b0;
    repeat (4) @(negedge clk_sys);
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h81);
    write_byte(8'h3A);
    write_byte(8'h55);
    write_byte(8'h81);
    ps2_clk_in = 1'b1;
    wait_busy(1'b1, 20, "sim_start_timeout", n);
    repeat (22 * CLK_DIV - 1) @(negedge clk_sys);
    chk("sim_stop_low", int'(ps2_clk_out), 0);
    exp_q.push_back(8'h42);
    write_byte(8'h42);
    chk("sim_full", int'(full), 0);
    chk("sim_in_gap", int'(busy), 1);
    wait_drain(800, "sim_drain");

    // Asynchronous reset during the D5 LOW phase.
    write_byte(8'h6B);
    wait_busy(1'b1, 20, "rs_start_timeout", n);
    repeat (53) @(negedge clk_sys);
    chk("rs_d5_low", int'(ps2_clk_out), 0);
    #1 reset = 1'b1;
    #1;
    chk("rs_clk", int'(ps2_clk_out), 1);
    chk("rs_dat", int'(ps2_dat_out), 1);
    chk("rs_busy", int'(busy), 0);
    @(negedge clk_sys);
    reset = 1'b0;
    starts = 0;
    repeat (150) begin
      @(negedge clk_sys);
      if (busy || !ps2_clk_out) starts++;
    end
    chk("rs_no_frame", starts, 0);
    chk("rs_full", int'(full), 0);
    chk("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
